ntt_butterfly: RTL and testbench

Pipelined modular butterfly for Kyber-style polynomial transforms over q = 3329. Computes one Cooley-Tukey (forward NTT) or Gentleman-Sande (inverse NTT) butterfly per clock on 16-bit coefficient lanes. It is the arithmetic core instantiated by the NTT engine, which supplies operand pairs and twiddles from coefficient/ROM memories.

---
 rtl/butterfly_pkg.sv | 19 +
 rtl/mod_mul.sv | 51 +++++
 rtl/ntt_butterfly.sv | 162 ++++++++++++++++
 tb/tb_ntt_butterfly.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/butterfly_pkg.sv
// Shared constants and mode encodings for the modular butterfly datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package butterfly_pkg;

  localparam int BF_Q             = 3329;  // Kyber modulus
  localparam int BF_WIDTH         = 16;    // port width for coefficients and twiddles
  localparam int BF_CW            = 12;    // internal coefficient width, Q < 2^12
  localparam int BF_BARRETT_SHIFT = 24;    // 12x12 product width
  localparam int BF_MW            = 13;    // width of the Barrett constant
  localparam int BF_BARRETT_M     = (1 << BF_BARRETT_SHIFT) / BF_Q;  // 5039

  typedef enum logic [1:0] {
    MODE_NTT  = 2'b00,
    MODE_INTT = 2'b01,
    MODE_PASS = 2'b10
  } mode_t;

endpackage

// File: rtl/mod_mul.sv
// Pipelined Barrett modular multiplier: p = x*y mod Q for x, y in [0, Q-1].
// Latency: 2 cycles (registered product, then registered reduced result).
// Backpressure: none; accepts a new operand pair every cycle.
//
// Ports: clk, rst (async active-low), x/y operands, p canonical result.
module mod_mul
  import butterfly_pkg::*;
#(
  parameter int Q  = BF_Q,
  parameter int CW = BF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  output logic [CW-1:0] p
);

  localparam int PW = 2 * CW;
  localparam int QW = PW + BF_MW;
  localparam int CX = CW + 1;
  localparam int M  = (1 << BF_BARRETT_SHIFT) / Q;

  logic [PW-1:0]    prod;
  logic [QW-1:0]    qm;
  logic [BF_MW-1:0] qhat;
  logic [PW-1:0]    r;
  logic [CW:0]      r13;
  logic [CW:0]      red;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prod <= '0;
    else      prod <= PW'(x) * PW'(y);
  end

  // prod < 2^24, so the quotient estimate is short by at most one:
  // the remainder lands in [0, 2Q) and one subtraction suffices.
  always_comb begin
    qm   = QW'(prod) * QW'(M);
    qhat = BF_MW'(qm >> BF_BARRETT_SHIFT);
    r    = prod - PW'(qhat) * PW'(Q);
    r13  = CX'(r);
    red  = (r13 >= CX'(Q)) ? (r13 - CX'(Q)) : r13;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) p <= '0;
    else      p <= CW'(red);
  end

endmodule

// File: rtl/ntt_butterfly.sv
// Pipelined CT (NTT) / GS (INTT) butterfly mod Q, one butterfly per clock.
// Latency: 3 cycles; operands sampled at edge N are on c/d after edge N+3.
// Backpressure: none; a new operand set is accepted every cycle.
//
// Ports: clk, rst (async active-low, clears all pipeline state),
//        mode (00 NTT, 01 INTT, 1x pass-through), a/b operands, w twiddle,
//        c/d registered results, canonical and zero-extended to WIDTH.
// Optional: BUTTERFLY_INTT_HALVE_EN scales both INTT results by 2^-1 mod Q.
module ntt_butterfly
  import butterfly_pkg::*;
#(
  parameter int Q     = BF_Q,
  parameter int WIDTH = BF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] w,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d
);

  localparam int CW = BF_CW;
  localparam int CX = CW + 1;

  function automatic logic [CW-1:0] mod_add(input logic [CW-1:0] x, input logic [CW-1:0] y);
    logic [CW:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= CX'(Q)) s = s - CX'(Q);
    return s[CW-1:0];
  endfunction

  // 13-bit wrap-around makes x - y + Q exact when x < y.
  function automatic logic [CW-1:0] mod_sub(input logic [CW-1:0] x, input logic [CW-1:0] y);
    logic [CW:0] s;
    s = {1'b0, x} - {1'b0, y};
    if (x < y) s = s + CX'(Q);
    return s[CW-1:0];
  endfunction

`ifdef BUTTERFLY_INTT_HALVE_EN
  // x/2 mod Q: odd x becomes even after adding the odd modulus.
  function automatic logic [CW-1:0] mod_half(input logic [CW-1:0] x);
    logic [CW:0] s;
    if (x[0]) s = ({1'b0, x} + CX'(Q)) >> 1;
    else      s = {1'b0, x} >> 1;
    return s[CW-1:0];
  endfunction
`endif

  logic [CW-1:0] a12, b12, w12;
  logic          unused_hi;

  assign a12       = a[CW-1:0];
  assign b12       = b[CW-1:0];
  assign w12       = w[CW-1:0];
  assign unused_hi = ^{a[WIDTH-1:CW], b[WIDTH-1:CW], w[WIDTH-1:CW]};

  // Stage 1: y carries the add path, x feeds the multiplier (or passes b).
  mode_t         mode_dec;
  logic [CW-1:0] y1, x1;

  always_comb begin
    mode_dec = MODE_PASS;
    y1       = a12;
    x1       = b12;
    case (mode)
      MODE_NTT:  mode_dec = MODE_NTT;
      MODE_INTT: begin
        mode_dec = MODE_INTT;
        y1       = mod_add(a12, b12);
        x1       = mod_sub(a12, b12);
      end
      default: ;
    endcase
  end

  mode_t         p1_mode, p2_mode, p3_mode;
  logic [CW-1:0] p1_y, p2_y, p3_y;
  logic [CW-1:0] p1_x, p2_x, p3_x;
  logic [CW-1:0] p1_w;
  logic [CW-1:0] t3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p1_mode <= MODE_NTT;
      p1_y    <= '0;
      p1_x    <= '0;
      p1_w    <= '0;
    end else begin
      p1_mode <= mode_dec;
      p1_y    <= y1;
      p1_x    <= x1;
      p1_w    <= w12;
    end
  end

  // Stage 2: shared multiplier (w*b for NTT, w*(a-b) for INTT).
  mod_mul #(.Q(Q), .CW(CW)) u_mul (
    .clk (clk),
    .rst (rst),
    .x   (p1_x),
    .y   (p1_w),
    .p   (t3)
  );

  // Side-band delay line matching the two multiplier register stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p2_mode <= MODE_NTT;
      p2_y    <= '0;
      p2_x    <= '0;
      p3_mode <= MODE_NTT;
      p3_y    <= '0;
      p3_x    <= '0;
    end else begin
      p2_mode <= p1_mode;
      p2_y    <= p1_y;
      p2_x    <= p1_x;
      p3_mode <= p2_mode;
      p3_y    <= p2_y;
      p3_x    <= p2_x;
    end
  end

  // Stage 3: NTT add/sub, INTT alignment (optionally halved), or pass.
  logic [CW-1:0] c_nxt, d_nxt;

  always_comb begin
    c_nxt = p3_y;
    d_nxt = p3_x;
    case (p3_mode)
      MODE_NTT: begin
        c_nxt = mod_add(p3_y, t3);
        d_nxt = mod_sub(p3_y, t3);
      end
      MODE_INTT: begin
`ifdef BUTTERFLY_INTT_HALVE_EN
        c_nxt = mod_half(p3_y);
        d_nxt = mod_half(t3);
`else
        c_nxt = p3_y;
        d_nxt = t3;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c <= '0;
      d <= '0;
    end else begin
      c <= {{(WIDTH-CW){1'b0}}, c_nxt};
      d <= {{(WIDTH-CW){1'b0}}, d_nxt};
    end
  end

endmodule

// File: tb/tb_ntt_butterfly.sv
module tb_ntt_butterfly;
  import butterfly_pkg::*;

  localparam int Q = 3329;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [15:0] a = '0, b = '0, w = '0;
  logic [15:0] c, d;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          due;
    logic [15:0] c;
    logic [15:0] d;
    string       name;
  } exp_t;

  exp_t sbq[$];

  ntt_butterfly dut (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .a    (a),
    .b    (b),
    .w    (w),
    .c    (c),
    .d    (d)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference butterfly straight from the modular-arithmetic definitions.
  function automatic void ref_bfly(input int m, input int av, input int bv, input int wv,
                                   output int cv, output int dv);
    int t;
    if (m == 0) begin
      t  = (wv * bv) % Q;
      cv = (av + t) % Q;
      dv = (av - t + Q) % Q;
    end else if (m == 1) begin
      cv = (av + bv) % Q;
      dv = (((av - bv + Q) % Q) * wv) % Q;
`ifdef BUTTERFLY_INTT_HALVE_EN
      cv = (cv * ((Q + 1) / 2)) % Q;
      dv = (dv * ((Q + 1) / 2)) % Q;
`endif
    end else begin
      cv = av;
      dv = bv;
    end
  endfunction

  // Called on a falling edge; operands are sampled at the next rising edge.
  task automatic send(input int m, input int av, input int bv, input int wv, input string nm);
    exp_t e;
    int   cv, dv;
    ref_bfly(m, av, bv, wv, cv, dv);
    mode   = 2'(m);
    a      = 16'(av);
    b      = 16'(bv);
    w      = 16'(wv);
    e.due  = cyc + 4;
    e.c    = 16'(cv);
    e.d    = 16'(dv);
    e.name = nm;
    sbq.push_back(e);
    @(negedge clk);
  endtask

  task automatic send_rand(input int m, input string nm);
    send(m, $urandom_range(Q - 1), $urandom_range(Q - 1), $urandom_range(Q - 1), nm);
  endtask

  // Monitor: results must appear exactly three edges after sampling, in order.
  always @(negedge clk) begin
    if (rst && sbq.size() > 0) begin
      if (sbq[0].due == cyc) begin
        exp_t e;
        e = sbq.pop_front();
        checks++;
        if (c !== e.c) begin
          failures++;
          $display("FAIL %s c: got %0d want %0d", e.name, c, e.c);
        end
        checks++;
        if (d !== e.d) begin
          failures++;
          $display("FAIL %s d: got %0d want %0d", e.name, d, e.d);
        end
      end else if (sbq[0].due < cyc) begin
        exp_t e;
        e = sbq.pop_front();
        checks++;
        failures++;
        $display("FAIL %s missed: cycle %0d due %0d", e.name, cyc, e.due);
      end
    end
  end

  task automatic check_zero(input string nm);
    checks++;
    if (c !== 16'd0 || d !== 16'd0) begin
      failures++;
      $display("FAIL %s: got c=%0d d=%0d want c=0 d=0", nm, c, d);
    end
  endtask

  initial begin
    // Reset held with live random inputs.
    for (int i = 0; i < 4; i++) begin
      mode = 2'($urandom_range(3));
      a    = 16'($urandom_range(Q - 1));
      b    = 16'($urandom_range(Q - 1));
      w    = 16'($urandom_range(Q - 1));
      @(negedge clk);
      check_zero("reset_hold");
    end
    rst = 1'b1;

    // Directed vectors.
    send(0, 52, 25, 68, "ntt_a");
    send(0, 418, 92, 147, "ntt_b");
    send(1, 461, 499, 847, "intt_a");
    send(1, 29, 136, 884, "intt_b");
    send(0, 3328, 1, 1, "ntt_bnd_hi");
    send(0, 0, 3328, 3328, "ntt_bnd_lo");
    send(1, 0, 0, $urandom_range(Q - 1), "intt_zero");
    send(2, 7, 9, $urandom_range(Q - 1), "pass_10");
    send(3, 7, 9, $urandom_range(Q - 1), "pass_11");

    // Streaming with mode toggling every cycle.
    for (int i = 0; i < 120; i++) send_rand(i % 4, "stream_toggle");
    for (int i = 0; i < 120; i++) send_rand(int'($urandom_range(3)), "stream_rand");

    // Asynchronous reset mid-stream, between clock edges.
    for (int i = 0; i < 6; i++) send_rand(i % 2, "pre_async");
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_zero("async_reset");
    sbq.delete();
    @(negedge clk);
    check_zero("async_reset_hold");
    rst = 1'b1;

    // Operation resumes cleanly after release.
    send(0, 52, 25, 68, "post_reset_ntt");
    for (int i = 0; i < 40; i++) send_rand(i % 3, "post_reset_stream");

    // Drain with a bounded wait.
    mode = 2'b00;
    a    = '0;
    b    = '0;
    w    = '0;
    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending results want 0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
